// File: rtl/player_missile.sv
// player_missile: single-missile launcher for the invaders playfield.
//   Launches from the ship on a fire-button edge, climbs MISSILE_STEP pixels
//   per frame tick, signals a one-cycle hit to one alien on overlap, exposes
//   its pixel mask for the color mapper and keeps a saturating hit counter.
// Ports:
//   Clk, Reset_n (async, active-low)    clock / reset
//   frame_clk                           vsync-rate strobe, async, edge-detected here
//   fire                                fire button level
//   ship_x/ship_y, alien_x_pos/y_pos    sprite centres
//   alien_dead                          suppresses collision
//   DrawX/DrawY                         current raster pixel
//   is_hit                              one-cycle hit pulse to the alien
//   is_missile                          current pixel is missile (combinational)
//   missile_active                      missile in flight
//   missile_x/missile_y                 missile centre
//   hit_count                           hits, saturating at 255
module player_missile #(
  parameter int MISSILE_STEP    = 8,
  parameter int LAUNCH_OFFSET   = 16,
  parameter int Y_MIN           = 8,
  parameter int HIT_HALF_W      = 11,
  parameter int HIT_HALF_H      = 9,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic [9:0] alien_x_pos,
  input  logic [9:0] alien_y_pos,
  input  logic       alien_dead,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_hit,
  output logic       is_missile,
  output logic       missile_active,
  output logic [9:0] missile_x,
  output logic [9:0] missile_y,
  output logic [7:0] hit_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLIGHT   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0]      CD_LAST  = CW'(COOLDOWN_FRAMES - 1);
  localparam logic [9:0]         LAUNCH_W = 10'(LAUNCH_OFFSET);
  localparam logic signed [10:0] STEP_S   = 11'(MISSILE_STEP);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] HW_S     = 11'(HIT_HALF_W);
  localparam logic signed [10:0] HH_S     = 11'(HIT_HALF_H);

  logic [1:0]    state;
  logic [CW-1:0] cd_cnt;
  logic [1:0]    frame_pipe;  // [0] synchroniser stage, [1] its delayed copy
  logic          frame_tick;
  logic          fire_d;
  logic          fire_edge;

  // ---- edge detection -------------------------------------------------------
  // frame_clk is asynchronous, so it gets one sampling flop before the edge
  // detector; fire is treated as already synchronous.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_pipe <= '0;
      frame_tick <= 1'b0;
      fire_d     <= 1'b0;
      fire_edge  <= 1'b0;
    end else begin
      frame_pipe <= {frame_pipe[0], frame_clk};
      frame_tick <= frame_pipe[0] & ~frame_pipe[1];
      fire_d     <= fire;
      fire_edge  <= fire & ~fire_d;
    end
  end

  // ---- signed geometry (11-bit so nothing wraps at 0/1023) ------------------
  logic signed [10:0] dx_hit, dy_hit, adx_hit, ady_hit;
  logic signed [10:0] next_y;
  logic signed [10:0] dx_pix, dy_pix;
  logic               collide;
  logic [9:0]         launch_y;

  always_comb begin
    dx_hit  = $signed({1'b0, missile_x}) - $signed({1'b0, alien_x_pos});
    dy_hit  = $signed({1'b0, missile_y}) - $signed({1'b0, alien_y_pos});
    adx_hit = (dx_hit < 0) ? -dx_hit : dx_hit;
    ady_hit = (dy_hit < 0) ? -dy_hit : dy_hit;
    collide = !alien_dead && (adx_hit <= HW_S) && (ady_hit <= HH_S);
    next_y  = $signed({1'b0, missile_y}) - STEP_S;
    // clamp spawn to the top row rather than wrapping below zero
    launch_y = (ship_y < LAUNCH_W) ? 10'd0 : ship_y - LAUNCH_W;
    dx_pix  = $signed({1'b0, DrawX}) - $signed({1'b0, missile_x});
    dy_pix  = $signed({1'b0, DrawY}) - $signed({1'b0, missile_y});
  end

  assign missile_active = (state == FLIGHT);
  // 3 wide (x-1..x+1) by 8 tall (y-4..y+3)
  assign is_missile = missile_active &&
                      (dx_pix >= -11'sd1) && (dx_pix <= 11'sd1) &&
                      (dy_pix >= -11'sd4) && (dy_pix <= 11'sd3);

  // ---- flight FSM ------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cd_cnt    <= '0;
      is_hit    <= 1'b0;
      missile_x <= '0;
      missile_y <= '0;
      hit_count <= '0;
    end else begin
      is_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_edge) begin
            missile_x <= ship_x;
            missile_y <= launch_y;
            state     <= FLIGHT;
          end
        end
        FLIGHT: begin
          // collision outranks a same-cycle frame step
          if (collide) begin
            is_hit <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            cd_cnt <= '0;
            state  <= COOLDOWN;
          end else if (frame_tick) begin
            if (next_y <= YMIN_S) begin
              cd_cnt <= '0;
              state  <= COOLDOWN;
            end else begin
              missile_y <= next_y[9:0];
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt == CD_LAST) state <= IDLE;
            else                   cd_cnt <= cd_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_missile.sv
// Directed bench for player_missile: launch, hit, miss, fire-edge discard,
// dead-alien suppression, spawn clamp, async reset, pixel mask and counter
// saturation, with hand-computed expectations.
module tb_player_missile;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] ship_x = 10'd320, ship_y = 10'd440;
  logic [9:0] alien_x_pos = 10'd400, alien_y_pos = 10'd200;
  logic       alien_dead = 1'b0;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
  logic       is_hit, is_missile, missile_active;
  logic [9:0] missile_x, missile_y;
  logic [7:0] hit_count;

  int checks = 0;
  int failures = 0;
  int hit_pulses = 0;
  int base;

  player_missile dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .ship_x(ship_x), .ship_y(ship_y),
    .alien_x_pos(alien_x_pos), .alien_y_pos(alien_y_pos),
    .alien_dead(alien_dead), .DrawX(DrawX), .DrawY(DrawY),
    .is_hit(is_hit), .is_missile(is_missile), .missile_active(missile_active),
    .missile_x(missile_x), .missile_y(missile_y), .hit_count(hit_count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (is_hit === 1'b1) hit_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fire_pulse();
    @(negedge Clk) fire = 1'b1;
    repeat (2) @(negedge Clk);
    fire = 1'b0;
    @(negedge Clk);
  endtask

  task automatic frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_pulse();
  endtask

  // alien parked on the spawn point: hit the cycle after launch, then cool down
  task automatic quick_hit();
    alien_x_pos = 10'd320; alien_y_pos = 10'd424;
    fire_pulse();
    frames(4);
  endtask

  initial begin
    // ---- reset state
    repeat (3) @(negedge Clk);
    chk("rst_active", 32'(missile_active), 0);
    chk("rst_hit", 32'(is_hit), 0);
    chk("rst_mask", 32'(is_missile), 0);
    chk("rst_x", 32'(missile_x), 0);
    chk("rst_y", 32'(missile_y), 0);
    chk("rst_count", 32'(hit_count), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // ---- straight-up hit on alien at (320,200)
    alien_x_pos = 10'd320; alien_y_pos = 10'd200;
    base = hit_pulses;
    fire_pulse();
    chk("launch_active", 32'(missile_active), 1);
    chk("launch_x", 32'(missile_x), 320);
    chk("launch_y", 32'(missile_y), 424);
    frames(26);
    chk("y_after26", 32'(missile_y), 216);
    chk("no_hit_yet", 32'(hit_pulses - base), 0);
    frame_pulse();
    chk("hit_y", 32'(missile_y), 208);
    chk("hit_once", 32'(hit_pulses - base), 1);
    chk("hit_count1", 32'(hit_count), 1);
    chk("hit_inactive", 32'(missile_active), 0);
    // fire edge inside cooldown is dropped
    frames(3);
    fire_pulse();
    repeat (3) @(negedge Clk);
    chk("cool_fire_drop", 32'(missile_active), 0);
    frame_pulse();

    // ---- miss against alien at (400,200), fire held throughout
    alien_x_pos = 10'd400; alien_y_pos = 10'd200;
    base = hit_pulses;
    @(negedge Clk) fire = 1'b1;
    repeat (3) @(negedge Clk);
    chk("miss_launch", 32'(missile_active), 1);
    chk("miss_launch_y", 32'(missile_y), 424);
    frames(10);
    fire = 1'b0; repeat (2) @(negedge Clk);
    fire = 1'b1; repeat (3) @(negedge Clk);
    chk("flight_fire_y", 32'(missile_y), 344);
    chk("flight_fire_act", 32'(missile_active), 1);
    frames(41);
    chk("y_after51", 32'(missile_y), 16);
    chk("act_after51", 32'(missile_active), 1);
    frame_pulse();
    chk("miss_inactive", 32'(missile_active), 0);
    chk("miss_y_hold", 32'(missile_y), 16);
    chk("miss_no_hit", 32'(hit_pulses - base), 0);
    frames(2);
    fire = 1'b0; repeat (2) @(negedge Clk);
    fire = 1'b1; repeat (3) @(negedge Clk);
    chk("cool_edge_drop", 32'(missile_active), 0);
    frames(2);
    repeat (3) @(negedge Clk);
    chk("held_no_relaunch", 32'(missile_active), 0);
    fire = 1'b0; @(negedge Clk);
    fire_pulse();
    chk("relaunch", 32'(missile_active), 1);
    chk("relaunch_y", 32'(missile_y), 424);
    alien_x_pos = 10'd320; alien_y_pos = 10'd424;
    repeat (2) @(negedge Clk);
    chk("hit_count2", 32'(hit_count), 2);
    frames(4);

    // ---- dead alien on the flight path: no hit, flies to the miss
    alien_x_pos = 10'd320; alien_y_pos = 10'd200; alien_dead = 1'b1;
    base = hit_pulses;
    fire_pulse();
    frames(52);
    chk("dead_no_hit", 32'(hit_pulses - base), 0);
    chk("dead_inactive", 32'(missile_active), 0);
    chk("dead_y", 32'(missile_y), 16);
    chk("dead_count", 32'(hit_count), 2);
    frames(4);
    alien_dead = 1'b0;

    // ---- spawn clamp near the top edge, mask must not wrap
    alien_x_pos = 10'd400; alien_y_pos = 10'd200;
    ship_y = 10'd10;
    fire_pulse();
    chk("clamp_y", 32'(missile_y), 0);
    chk("clamp_active", 32'(missile_active), 1);
    DrawX = 10'd320; DrawY = 10'd1; #1;
    chk("mask_y1", 32'(is_missile), 1);
    DrawY = 10'd1020; #1;
    chk("mask_wrap1020", 32'(is_missile), 0);
    DrawY = 10'd1023; #1;
    chk("mask_wrap1023", 32'(is_missile), 0);
    frame_pulse();
    chk("clamp_miss", 32'(missile_active), 0);
    frames(4);
    ship_y = 10'd440;

    // ---- async reset mid-flight with hit_count 3
    quick_hit();
    chk("hit_count3", 32'(hit_count), 3);
    alien_x_pos = 10'd400; alien_y_pos = 10'd200;
    fire_pulse();
    DrawX = 10'd320; DrawY = 10'd424; #1;
    chk("pre_rst_mask", 32'(is_missile), 1);
    @(negedge Clk); #2 Reset_n = 1'b0; #1;
    chk("arst_active", 32'(missile_active), 0);
    chk("arst_mask", 32'(is_missile), 0);
    chk("arst_x", 32'(missile_x), 0);
    chk("arst_y", 32'(missile_y), 0);
    chk("arst_count", 32'(hit_count), 0);
    chk("arst_hit", 32'(is_hit), 0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_rst_idle", 32'(missile_active), 0);

    // ---- pixel mask sweep around (320,424)
    fire_pulse();
    chk("sweep_launch", 32'(missile_active), 1);
    for (int dy = -6; dy <= 5; dy++) begin
      for (int dx = -3; dx <= 3; dx++) begin
        DrawX = 10'(320 + dx); DrawY = 10'(424 + dy); #1;
        chk($sformatf("mask_%0d_%0d", dx, dy), 32'(is_missile),
            32'((dx >= -1 && dx <= 1 && dy >= -4 && dy <= 3) ? 1 : 0));
      end
    end
    alien_x_pos = 10'd320; alien_y_pos = 10'd424;
    repeat (2) @(negedge Clk);
    chk("sweep_hit_count", 32'(hit_count), 1);
    frames(4);

    // ---- saturation
    for (int i = 0; i < 254; i++) quick_hit();
    chk("count_255", 32'(hit_count), 255);
    base = hit_pulses;
    quick_hit();
    chk("count_sat", 32'(hit_count), 255);
    chk("sat_pulse", 32'(hit_pulses - base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop in case anything stalls
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/player_missile.md
# player_missile

Player missile unit for the invaders playfield. It launches a single missile from the ship on a fire-button press and steps it upward once per frame. It detects overlap with one alien and drives that alien's `is_hit` input, which puts it directly upstream of the alien sprite block. It also provides the missile's pixel mask to the color mapper and keeps a saturating hit counter for the score display.

## Interface
- `MISSILE_STEP`, 8: pixels moved up per frame tick.
- `LAUNCH_OFFSET`, 16: spawn y = ship_y − LAUNCH_OFFSET.
- `Y_MIN`, 8: the missile is out of bounds when next y ≤ Y_MIN.
- `HIT_HALF_W`, 11: horizontal collision half-width around the alien centre.
- `HIT_HALF_H`, 9: vertical collision half-height around the alien centre.
- `COOLDOWN_FRAMES`, 4: frame ticks spent in COOLDOWN before the unit can re-arm.

Ports:
- `Clk`, in, 1: system clock.
- `Reset_n`, in, 1: reset, asynchronous, active-low.
- `frame_clk`, in, 1: vertical-sync-rate strobe, asynchronous to frame logic, edge-detected internally.
- `fire`, in, 1: fire button, level.
- `ship_x`, `ship_y`, in, 10 each: ship centre.
- `alien_x_pos`, `alien_y_pos`, in, 10 each: alien centre.
- `alien_dead`, in, 1: the alien is already hit; collision is suppressed while this is high.
- `DrawX`, `DrawY`, in, 10 each: current pixel.
- `is_hit`, out, 1: one-Clk pulse to the alien on a collision.
- `is_missile`, out, 1: the current pixel belongs to the missile.
- `missile_active`, out, 1: high while the unit is in FLIGHT.
- `missile_x`, `missile_y`, out, 10 each: missile centre.
- `hit_count`, out, 8: saturating hit counter.

## Operation
- Frame tick:
  - `frame_clk` is registered once.
  - `frame_tick` is registered as (frame_clk & ~frame_clk_d), so it is a one-Clk pulse that arrives two Clk after the rising edge.
- Fire edge:
  - `fire_edge` is registered as (fire & ~fire_d).
  - Holding `fire` produces exactly one edge.
- IDLE:
  - On `fire_edge`, load missile_x = ship_x and missile_y = ship_y − LAUNCH_OFFSET, then go to FLIGHT.
  - If ship_y < LAUNCH_OFFSET, missile_y = 0.
- FLIGHT, evaluated in this priority order every Clk:
  1. Collision is checked every Clk. The condition is !alien_dead AND |missile_x − alien_x_pos| ≤ HIT_HALF_W AND |missile_y − alien_y_pos| ≤ HIT_HALF_H. Differences are computed as 11-bit signed values, with no wrap.
  2. On collision: `is_hit` = 1 for exactly one Clk, `hit_count` increments (saturating at 255), the cooldown counter clears, and the unit goes to COOLDOWN.
  3. Otherwise, on `frame_tick`, compute next_y = missile_y − MISSILE_STEP in 11-bit signed. If next_y ≤ Y_MIN, the shot is a miss: go to COOLDOWN with no hit. Otherwise missile_y = next_y.
  4. Collision has priority over movement in the same cycle.
  5. `missile_x` does not change in flight.
- COOLDOWN:
  - Count frame ticks.
  - When the COOLDOWN_FRAMES-th tick arrives, go to IDLE.
  - A `fire_edge` during COOLDOWN or FLIGHT is discarded, not queued.
- Position registers hold their last value outside FLIGHT.
- `missile_active` = (state == FLIGHT).
- `is_missile` = FLIGHT AND DrawX ∈ [missile_x−1, missile_x+1] AND DrawY ∈ [missile_y−4, missile_y+3].
  - Comparisons are 11-bit signed, so no pixel appears near 0 or 1023 because of wrap.
  - `is_missile` is combinational from its inputs and state.
- State encoding: IDLE = 0, FLIGHT = 1, COOLDOWN = 2. The illegal value 3 → IDLE.

## Timing
- Reset values, applied asynchronously and held until Reset_n deasserts:
  - state = IDLE; is_hit = 0; missile_active = 0; is_missile = 0.
  - missile_x = 0; missile_y = 0; hit_count = 0.
  - Edge registers and the cooldown counter = 0.
- Fire latency:
  - `fire` rising at Clk n → `fire_edge` at n+1 → missile_active = 1 and position loaded at n+2.
- Frame latency:
  - `frame_clk` rising at Clk n → `frame_tick` at n+2 → missile_y updated at n+3.
- Hit latency:
  - Overlap present at Clk n → `is_hit` high during n+1 only.
  - missile_active = 0 from n+1.
- Simultaneous events:
  - Collision and `frame_tick` in the same cycle: the hit wins and y is not updated.
  - `alien_dead` rising in the same cycle as overlap: no hit.
- Reset mid-flight: the missile vanishes immediately and `hit_count` clears.
- `hit_count` at 255 with a further hit: it stays 255, and `is_hit` still pulses.

## Test plan
- Reset_n low mid-FLIGHT with a hit_count of 3 → all outputs go to zero asynchronously, and the state is IDLE after release.
- Ship (320,440), alien (320,200), fire pulse → missile at (320,424). After 27 frame ticks y = 208, and `is_hit` pulses exactly once. hit_count = 1, then COOLDOWN.
- Ship (320,440), alien (400,200), fire → y falls by 8 per tick. The 52nd tick (next_y = 8) is a miss with no `is_hit`. IDLE follows after 4 more ticks, and fire is accepted again.
- Fire held high through an entire flight, plus a second fire edge during FLIGHT and during COOLDOWN → only one missile is launched, and no re-launch happens until a new edge arrives in IDLE.
- Overlapping position with alien_dead = 1 → no `is_hit`, and the missile continues to the miss.
- hit_count preset to 255 by 255 hits, then one more hit → hit_count stays 255 and `is_hit` pulses. Sweep DrawX/DrawY around the missile at y = 424 → `is_missile` is high only in the 3×8 box.
